ctrlr_poll: RTL
===============

Name: ctrlr_poll

Overview:
- Downstream slave of mem_ctrl for the CTRLR0..CTRLR3 address window.
- Autonomously polls four SNES-style serial gamepads over a shared latch/clock pair with four data lines.
- Keeps a 16-bit button snapshot per pad.
- Returns the selected snapshot on din_ctrlrs when mem_ctrl asserts ctrlr_re with addr_ctrlr.

Parameters:
- CLK_DIV, 4: system clocks per pad-bus tick; each pad_latch or pad_clk phase lasts one tick. Must be >= 2.
- POLL_CYCLES, 64: idle clocks between the end of one frame and the start of the next latch pulse. Must be >= 1.
- NUM_BITS, 16: serial bits shifted per pad per frame.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low.
- ctrlr_re, input, 1: read enable from mem_ctrl.
- addr_ctrlr, input, 2: pad select from mem_ctrl (0..3 = CTRLR0..CTRLR3).
- din_ctrlrs, output, 16: read data to mem_ctrl; bit i = button i, 1 = pressed.
- pad_latch, output, 1: shared latch to pads, active high.
- pad_clk, output, 1: shared shift clock to pads; idles high.
- pad_data, input, 4: serial data, one line per pad; active-low (0 = pressed). Unconnected lines are pulled high.
- poll_busy, output, 1: high from LATCH entry through COMMIT inclusive.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: din_ctrlrs=0, pad_latch=0, pad_clk=1, poll_busy=0.
  - Internal: all four snapshot registers and the shadow registers =0; poll counter, tick divider and bit counter =0; FSM=IDLE.
  - Reset mid-frame aborts the frame; the partial shadow is discarded and snapshots are cleared.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, COMMIT.
- IDLE:
  - Poll counter increments each clock.
  - On the edge where it equals POLL_CYCLES-1: counter clears, go to LATCH, tick divider clears.
- LATCH:
  - pad_latch=1 for exactly 2*CLK_DIV clocks, then go to CLK_LO with bit counter=0.
  - pad_latch returns to 0 on that same transition edge.
- CLK_LO:
  - On the entry edge, shadow[p][bit] <= ~pad_data[p] for p=0..3. This samples the bit presented during the preceding LATCH or CLK_HI phase.
  - pad_clk=0 for CLK_DIV clocks, then go to CLK_HI.
- CLK_HI:
  - pad_clk=1 for CLK_DIV clocks.
  - If bit==NUM_BITS-1, go to COMMIT; else bit+1 and go to CLK_LO.
- COMMIT:
  - One clock: all four snapshots <= shadows atomically, then go to IDLE.
- Frame length from LATCH entry to IDLE re-entry: 2*CLK_DIV + 2*NUM_BITS*CLK_DIV + 1 clocks (137 at defaults).
- Read path:
  - Registered, 1-clock latency: if ctrlr_re==1 at an edge, din_ctrlrs <= snapshot[addr_ctrlr].
  - Otherwise din_ctrlrs holds its last value.
  - Reads never stall or disturb polling.
- Simultaneous read and COMMIT on the same edge: read returns the pre-commit snapshot; the next read returns the new one.
- Back-to-back reads with changing addr_ctrlr return each addressed pad on consecutive cycles.
- Pad data is sampled with no synchroniser inside this block; the pad pins are registered at the top level.
- Unconnected pad: all-1 data reads back as 16'h0000.

Test Plan:
- Reset: hold rst=0 for 3 clocks with random pad_data -> din_ctrlrs=0, pad_latch=0, pad_clk=1, poll_busy=0; after release, pad_latch rises exactly 64 clocks later.
- Frame timing at defaults: measure one frame -> pad_latch high 8 clocks; 16 pad_clk low pulses, each 4 clocks low / 4 high; poll_busy high 137 clocks.
- Data capture:
  - Bench pad models shift patterns; pressed patterns are 16'hA5C3, 16'h0001, 16'h8000, 16'h0000 for pads 0-3.
  - Data lines drive the inverted values.
  - After COMMIT, reads of addr 0..3 -> exactly those four values, each 1 clock after ctrlr_re.
- Read collision: assert ctrlr_re, addr 0, on the COMMIT edge of a frame changing pad0 from 16'h0000 to 16'h00FF -> that read returns 16'h0000; the read on the next clock returns 16'h00FF.
- Mid-frame reset: pull rst low during CLK_LO of bit 7 -> snapshots cleared; pad_clk=1, pad_latch=0 next clock; the full new frame starts POLL_CYCLES clocks after release.
- Hold behaviour: ctrlr_re=0 while a frame updates snapshots -> din_ctrlrs stays at the last read value.

Source files
------------

// File: rtl/ctrlr_poll.sv
// ctrlr_poll: autonomous poller for four SNES-style serial gamepads.
// The pads share one latch/clock pair, and each pad drives its own data line.
// A complete 16-bit button frame is shifted into shadow registers.
// All four snapshots are then updated together on one clock, so a read never sees a torn frame.
// mem_ctrl reads a snapshot through a registered port with 1-clock latency.

module ctrlr_poll #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned POLL_CYCLES = 64,
    parameter int unsigned NUM_BITS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrlr_re,
    input  logic [1:0]  addr_ctrlr,
    output logic [15:0] din_ctrlrs,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [3:0]  pad_data,
    output logic        poll_busy
);

    localparam int unsigned NumPads = 4;
    localparam int unsigned PollW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned TickW   = $clog2(2 * CLK_DIV);
    localparam int unsigned BitW    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYCLES - 1);
    localparam logic [TickW-1:0] LatchLast = TickW'(2 * CLK_DIV - 1);
    localparam logic [TickW-1:0] PhaseLast = TickW'(CLK_DIV - 1);
    localparam logic [BitW-1:0]  BitLast   = BitW'(NUM_BITS - 1);

    // Reject parameter values the bus timing cannot support.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("ctrlr_poll: CLK_DIV must be >= 2");
    end
    if (POLL_CYCLES < 1) begin : g_bad_poll
        $error("ctrlr_poll: POLL_CYCLES must be >= 1");
    end
    if (NUM_BITS < 1 || NUM_BITS > 16) begin : g_bad_bits
        $error("ctrlr_poll: NUM_BITS must be in 1..16");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StClkLo,
        StClkHi,
        StCommit
    } state_e;

    state_e             state_q, state_d;
    logic [PollW-1:0]   poll_q, poll_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [15:0]        shadow_q [NumPads];
    logic [15:0]        shadow_d [NumPads];
    logic [15:0]        snap_q [NumPads];
    logic [15:0]        snap_d [NumPads];
    logic [15:0]        din_q, din_d;
    logic               latch_q, latch_d;
    logic               pclk_q, pclk_d;
    logic               busy_q, busy_d;
    logic               sample;
    logic               commit;

    // Sequencer: idle gap, latch pulse, NUM_BITS clock pulses, then a one-clock commit.
    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sample  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (poll_q == PollLast) begin
                    poll_d  = '0;
                    tick_d  = '0;
                    state_d = StLatch;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
            end
            StLatch: begin
                if (tick_q == LatchLast) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    sample  = 1'b1;
                    state_d = StClkLo;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StClkLo: begin
                if (tick_q == PhaseLast) begin
                    tick_d  = '0;
                    state_d = StClkHi;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StClkHi: begin
                if (tick_q == PhaseLast) begin
                    tick_d = '0;
                    if (bit_q == BitLast) begin
                        state_d = StCommit;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sample  = 1'b1;
                        state_d = StClkLo;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Each CLK_LO entry captures the bit the pads presented during the preceding phase.
    // The data lines are active-low, so the captured bit is inverted to 1 = pressed.
    always_comb begin
        for (int p = 0; p < NumPads; p++) begin
            shadow_d[p] = shadow_q[p];
            if (sample) begin
                shadow_d[p][bit_d] = ~pad_data[p];
            end
        end
    end

    // Copy all shadows into the snapshots together on the commit clock.
    always_comb begin
        for (int p = 0; p < NumPads; p++) begin
            snap_d[p] = commit ? shadow_q[p] : snap_q[p];
        end
    end

    // Registered read port. It uses the pre-commit snapshot when the read and the commit share an edge.
    always_comb begin
        din_d = din_q;
        if (ctrlr_re) begin
            din_d = snap_q[addr_ctrlr];
        end
    end

    // The pad-bus outputs are decoded from the next state and registered, so the pins never glitch.
    always_comb begin
        latch_d = (state_d == StLatch);
        pclk_d  = (state_d != StClkLo);
        busy_d  = (state_d != StIdle);
    end

    // State and data registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            poll_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            din_q   <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            for (int p = 0; p < NumPads; p++) begin
                shadow_q[p] <= '0;
                snap_q[p]   <= '0;
            end
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            din_q   <= din_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            busy_q  <= busy_d;
            for (int p = 0; p < NumPads; p++) begin
                shadow_q[p] <= shadow_d[p];
                snap_q[p]   <= snap_d[p];
            end
        end
    end

    assign din_ctrlrs = din_q;
    assign pad_latch  = latch_q;
    assign pad_clk    = pclk_q;
    assign poll_busy  = busy_q;

endmodule
